// File: rtl/alu_pkg.sv
// Shared opcode and state types for the ALU responder.
// Imported by alu and alu_responder.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } resp_state_t;

endpackage

// File: rtl/alu_responder_alu.sv
// Combinational ALU: add/sub wrap, logic ops, barrel shifts,
// signed set-less-than.
module alu
  import alu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  alu_op_t      op,
  output logic [n-1:0] y
);

  localparam int SH_W = $clog2(n);

  logic [SH_W-1:0] sh;
  logic            lt;

  assign sh = b[SH_W-1:0];
  assign lt = $signed(a) < $signed(b);

  // One result per opcode; every encoding is decoded.
  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << sh;
      ALU_SRL: y = a >> sh;
      ALU_SLT: y = {{(n-1){1'b0}}, lt};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_responder.sv
// Handshaked ALU front end: one op at a time, iterative shifts.
// Optional counters under `ALU_RESPONDER_STATS_EN.
module alu_responder
  import alu_pkg::*;
#(
  parameter int N       = 32,
  parameter int TAG_W   = 4,
  parameter int SHAMT_W = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [N-1:0]        req_a,
  input  logic [N-1:0]        req_b,
  input  logic [ALU_OP_W-1:0] req_op,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [N-1:0]        rsp_result,
  output logic                rsp_zero,
`ifdef ALU_RESPONDER_STATS_EN
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [31:0]         stat_ops,
  output logic [31:0]         stat_stall
`else
  output logic [TAG_W-1:0]    rsp_tag
`endif
);

  resp_state_t        state_q, state_d;
  alu_op_t            op_q, op_d;
  alu_op_t            req_op_e;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [N-1:0]       work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]       rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;

  logic [N-1:0]       alu_y;
  logic [N-1:0]       work_sh;
  logic [N-1:0]       first_res;
  logic [SHAMT_W-1:0] req_shamt;
  logic               req_is_shift;

  assign req_op_e     = alu_op_t'(req_op);
  assign req_shamt    = req_b[SHAMT_W-1:0];
  assign req_is_shift = (req_op_e == ALU_SLL) ||
                        (req_op_e == ALU_SRL);

  alu #(.n(N)) u_alu (
    .a  (req_a),
    .b  (req_b),
    .op (req_op_e),
    .y  (alu_y)
  );

  // Shifts bypass the ALU: a zero shift returns a unchanged.
  assign first_res = req_is_shift ? req_a : alu_y;

  // One bit per cycle, zero fill on the right shift.
  assign work_sh = (op_q == ALU_SLL) ? (work_q << 1)
                                     : (work_q >> 1);

  // Next-state, iterator and response register update.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_tag_d    = rsp_tag_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d   = req_op_e;
          tag_d  = req_tag;
          work_d = req_a;
          cnt_d  = req_shamt;
          if (req_is_shift && (req_shamt != '0)) begin
            state_d = SHIFT;
          end else begin
            state_d      = RESP;
            rsp_result_d = first_res;
            rsp_zero_d   = ~|first_res;
            rsp_tag_d    = req_tag;
          end
        end
      end
      SHIFT: begin
        work_d = work_sh;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d      = RESP;
          rsp_result_d = work_sh;
          rsp_zero_d   = ~|work_sh;
          rsp_tag_d    = tag_q;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      op_q         <= ALU_ADD;
      tag_q        <= '0;
      work_q       <= '0;
      cnt_q        <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_tag    = rsp_tag_q;

`ifdef ALU_RESPONDER_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Completed responses and backpressured cycles, wrapping.
  always_comb begin
    stat_ops_d   = stat_ops_q;
    stat_stall_d = stat_stall_q;
    if (rsp_valid && rsp_ready)  stat_ops_d   = stat_ops_q + 32'd1;
    if (rsp_valid && !rsp_ready) stat_stall_d = stat_stall_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_ops_q   <= stat_ops_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_responder.sv
// Directed-vector bench for alu_responder.
// Define ALU_RESPONDER_STATS_EN to also check the counters.
module tb_alu_responder;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [3:0]  rsp_tag;
`ifdef ALU_RESPONDER_STATS_EN
  logic [31:0] stat_ops;
  logic [31:0] stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
`ifdef ALU_RESPONDER_STATS_EN
    .rsp_tag    (rsp_tag),
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall)
`else
    .rsp_tag    (rsp_tag)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Present one request; return edges until rsp_valid.
  task automatic send(input alu_op_t op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [3:0] tag,
                      output int lat);
    @(negedge clk);
    chk("ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'hFFFF_FFFF;
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Full op with rsp_ready held high.
  task automatic run_op(input string nm,
                        input alu_op_t op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [3:0] tag,
                        input logic [31:0] exp_r,
                        input int exp_lat);
    int lat;
    send(op, a, b, tag, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_res"}, rsp_result, exp_r);
    chk({nm, "_zero"}, {31'b0, rsp_zero},
        {31'b0, exp_r == 32'd0});
    chk({nm, "_tag"}, {28'b0, rsp_tag}, {28'b0, tag});
    @(posedge clk);
    #1;
    chk({nm, "_done"}, {30'b0, rsp_valid, req_ready},
        32'd1);
  endtask

  initial begin
    int lat;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    #12;
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_res", rsp_result, 32'd0);
    chk("rst_zero", {31'b0, rsp_zero}, 32'd0);
    chk("rst_tag", {28'b0, rsp_tag}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Backpressure with stray requests while busy.
    rsp_ready = 1'b0;
    send(ALU_AND, 32'hABCD_EF00, 32'h00FF_00FF, 4'h7, lat);
    chk("and_lat", 32'(lat), 32'd1);
    req_valid = 1'b1;
    req_op    = ALU_OR;
    req_a     = 32'h1111_1111;
    req_tag   = 4'h3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_res", rsp_result, 32'h00CD_0000);
      chk("bp_tag", {28'b0, rsp_tag}, 32'h7);
      chk("bp_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel", {30'b0, rsp_valid, req_ready}, 32'd1);
`ifdef ALU_RESPONDER_STATS_EN
    chk("stat_stall", stat_stall, 32'd5);
    chk("stat_ops", stat_ops, 32'd1);
`endif

    run_op("add", ALU_ADD, 32'h1234_5678, 32'h8765_4321,
           4'h1, 32'h9999_9999, 1);
    run_op("sub", ALU_SUB, 32'h8765_4321, 32'h1234_5678,
           4'h2, 32'h7530_ECA9, 1);
    run_op("subz", ALU_SUB, 32'h0000_BEEF, 32'h0000_BEEF,
           4'h3, 32'h0, 1);
    run_op("sll", ALU_SLL, 32'hABCD_EF00, 32'd5,
           4'h4, 32'h79BD_E000, 6);
    run_op("srl", ALU_SRL, 32'hABCD_EF00, 32'd5,
           4'h5, 32'h055E_6F78, 6);
    run_op("sh0", ALU_SLL, 32'hABCD_EF00, 32'h0000_0020,
           4'h6, 32'hABCD_EF00, 1);
    run_op("slt0", ALU_SLT, 32'h1234_5678, 32'hABCD_EF00,
           4'h8, 32'h0, 1);
    run_op("slt1", ALU_SLT, 32'hABCD_EF00, 32'h1234_5678,
           4'h9, 32'h1, 1);
    run_op("xor", ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00,
           4'hA, 32'h0FF0_0FF0, 1);
    run_op("sll31", ALU_SLL, 32'h0000_0003, 32'd31,
           4'hB, 32'h8000_0000, 32);

    // Abort an SLL by 20 in its third shift cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = ALU_SLL;
    req_a     = 32'h0000_0001;
    req_b     = 32'd20;
    req_tag   = 4'hC;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_res_pre", rsp_result, 32'h8000_0000);
    reset_n = 1'b0;
    #1;
    chk("ab_res", rsp_result, 32'd0);
    chk("ab_tag", {28'b0, rsp_tag}, 32'd0);
    chk("ab_valid", {31'b0, rsp_valid}, 32'd0);
`ifdef ALU_RESPONDER_STATS_EN
    chk("ab_stat", stat_ops, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      chk("ab_quiet", {30'b0, rsp_valid, req_ready}, 32'd1);
    end
    run_op("add2", ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001,
           4'hD, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
